// File: rtl/fetch_unit.sv
// fetch_unit: program counter / fetch sequencer with a 4-entry absolute branch-target LUT.
// Optional FETCH_LUT_WR_EN adds a runtime write port to the LUT.
module fetch_unit #(
  parameter int PC_W = 10,
  parameter logic [PC_W-1:0] TARG0 = '0,
  parameter logic [PC_W-1:0] TARG1 = '0,
  parameter logic [PC_W-1:0] TARG2 = '0,
  parameter logic [PC_W-1:0] TARG3 = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic            Zero,
  input  logic            Ack,
  input  logic [PC_W-1:0] PCTarg,
`ifdef FETCH_LUT_WR_EN
  input  logic            LutWrEn,
  input  logic [1:0]      LutWrIdx,
  input  logic [PC_W-1:0] LutWrData,
`endif
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            BranchTaken
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_targ;
  logic            r_running, r_done, r_bt;
  logic            w_adv, w_redir, w_bt_next, w_running, w_done;
  logic            w_unused;
  assign w_unused = ^PCTarg[PC_W-1:2];
`ifdef FETCH_LUT_WR_EN
  logic [PC_W-1:0] r_lut [4];
  // Reads see the pre-write entry, so a same-cycle redirect uses the old target.
  always_ff @(posedge Clk)
    if (Reset) begin
      r_lut[0] <= TARG0;
      r_lut[1] <= TARG1;
      r_lut[2] <= TARG2;
      r_lut[3] <= TARG3;
    end else if (LutWrEn) r_lut[LutWrIdx] <= LutWrData;
  assign w_targ = r_lut[PCTarg[1:0]];
`else
  assign w_targ = PCTarg[1] ? (PCTarg[0] ? TARG3 : TARG2) : (PCTarg[0] ? TARG1 : TARG0);
`endif
  always_ff @(posedge Clk)
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_bt      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pc      <= w_pc_next;
      r_running <= w_running;
      r_done    <= w_done;
      r_bt      <= w_bt_next;
    end
  always_comb begin
    w_adv   = (r_state == S_RUN) && !Stall;
    w_redir = w_adv && !Ack && (Jump || (BranchEn && Zero));
    w_next  = (r_state == S_RUN) ? ((w_adv && Ack) ? S_HALT : S_RUN)
                                 : (Start ? S_RUN : r_state);
  end
  always_comb begin
    w_pc_next = (r_state != S_RUN) ? (Start ? '0 : r_pc)
              : (!w_adv || Ack)    ? r_pc
              : w_redir            ? w_targ
              :                      r_pc + 1'b1;
    w_bt_next = w_redir;
    w_running = (w_next == S_RUN);
    w_done    = (w_next == S_HALT);
  end
  assign ProgCtr     = r_pc;
  assign Running     = r_running;
  assign Done        = r_done;
  assign BranchTaken = r_bt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a behavioural fetch model; a second PC_W=4 instance checks wrap.
module tb_fetch_unit;
  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic       Reset = 1'b1, Start = 1'b0, Stall = 1'b0, Jump = 1'b0, BranchEn = 1'b0, Zero = 1'b0, Ack = 1'b0;
  logic [9:0] PCTarg = '0;
  logic [9:0] pc;
  logic       run, done, bt;
  logic [3:0] pc4;
  logic       run4, done4, bt4;
`ifdef FETCH_LUT_WR_EN
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [9:0] wr_data = '0;
`endif
  int n_chk = 0, n_fail = 0;
  int m_mode = 0, m_pc = 0, m_bt = 0, m4_run = 0, m4_pc = 0;
  int m_lut [4] = '{0, 3, 40, 100};

  fetch_unit #(.PC_W(10), .TARG0(10'd0), .TARG1(10'd3), .TARG2(10'd40), .TARG3(10'd100)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Jump(Jump), .BranchEn(BranchEn),
    .Zero(Zero), .Ack(Ack), .PCTarg(PCTarg),
`ifdef FETCH_LUT_WR_EN
    .LutWrEn(wr_en), .LutWrIdx(wr_idx), .LutWrData(wr_data),
`endif
    .ProgCtr(pc), .Running(run), .Done(done), .BranchTaken(bt));

  fetch_unit #(.PC_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(1'b0), .Jump(1'b0), .BranchEn(1'b0),
    .Zero(1'b0), .Ack(1'b0), .PCTarg(4'd0),
`ifdef FETCH_LUT_WR_EN
    .LutWrEn(1'b0), .LutWrIdx(2'd0), .LutWrData(4'd0),
`endif
    .ProgCtr(pc4), .Running(run4), .Done(done4), .BranchTaken(bt4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs, s, st, j, b, z, a, input logic [9:0] t);
    Reset = rs; Start = s; Stall = st; Jump = j; BranchEn = b; Zero = z; Ack = a; PCTarg = t;
    @(posedge Clk);
    if (rs) begin
      m_mode = 0; m_pc = 0; m_bt = 0; m4_run = 0; m4_pc = 0;
      m_lut = '{0, 3, 40, 100};
    end else begin
      if (m_mode != 1) begin
        if (s) begin m_mode = 1; m_pc = 0; end
        m_bt = 0;
      end else if (st) m_bt = 0;
      else if (a) begin m_mode = 2; m_bt = 0; end
      else if (j || (b && z)) begin m_pc = m_lut[t % 4]; m_bt = 1; end
      else begin m_pc = (m_pc + 1) % 1024; m_bt = 0; end
      if (m4_run != 0) m4_pc = (m4_pc + 1) % 16;
      else if (s) begin m4_run = 1; m4_pc = 0; end
`ifdef FETCH_LUT_WR_EN
      if (wr_en) m_lut[wr_idx] = int'(wr_data);
`endif
    end
    #1;
    chk("pc", pc, m_pc);
    chk("running", run, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("branch_taken", bt, m_bt);
    chk("pc4", pc4, m4_pc);
    chk("running4", run4, m4_run);
    chk("done4", done4, 0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    chk("reset_pc", pc, 0);
    chk("reset_running", run, 0);
    nop(2);
    chk("idle_hold_pc", pc, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("start_pc0", pc, 0);
    chk("start_running", run, 1);
    nop(3);
    chk("seq_pc3", pc, 3);
    nop(2);
    step(0, 0, 0, 1, 0, 0, 0, 10'd2);
    chk("jump_pc40", pc, 40);
    chk("jump_bt", bt, 1);
    nop(1);
    chk("bt_one_cycle", bt, 0);
    chk("after_jump_pc41", pc, 41);
    step(0, 0, 0, 1, 0, 0, 0, 10'd0);
    nop(7);
    step(0, 0, 0, 0, 1, 0, 0, 10'd1);
    chk("branch_nz_pc8", pc, 8);
    step(0, 0, 0, 0, 1, 1, 0, 10'h3F5);
    chk("branch_z_pc3", pc, 3);
    nop(6);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, 10'd2);
    chk("stall_pc9", pc, 9);
    nop(1);
    chk("release_pc10", pc, 10);
    nop(2);
    step(0, 0, 0, 1, 0, 0, 1, 10'd2);
    chk("ack_pc12", pc, 12);
    chk("ack_done", done, 1);
    for (int i = 0; i < 10; i++) step(0, 0, i[0], 1, 1, 1, 1, 10'd2);
    chk("halt_hold_pc12", pc, 12);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("restart_pc0", pc, 0);
    chk("restart_done", done, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("start_in_run_ignored", pc, 1);
    nop(5);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("midrun_reset_pc", pc, 0);
    chk("midrun_reset_running", run, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    nop(4);
`ifdef FETCH_LUT_WR_EN
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 10'd20;
    step(0, 0, 0, 1, 0, 0, 0, 10'd0);
    wr_en = 1'b0;
    chk("lut_old_target", pc, 0);
    step(0, 0, 0, 1, 0, 0, 0, 10'd0);
    chk("lut_new_target", pc, 20);
`endif
    for (int i = 0; i < 400; i++) begin
`ifdef FETCH_LUT_WR_EN
      wr_en = ($urandom_range(0, 7) == 0); wr_idx = 2'($urandom); wr_data = 10'($urandom);
`endif
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           $urandom_range(0, 14) == 0, 10'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
